time_display_scanner: RTL and testbench
=======================================

# time_display_scanner

Downstream display stage for the binary clock. It consumes the registered `Hours`, `Minutes` and `Seconds` values and drives a 4-digit, common-anode, multiplexed seven-segment display. The display shows either HH.MM or MM.SS in decimal. Each frame is snapshotted atomically so that a clock rollover mid-scan never produces a torn display.

## Interface
- `REFRESH_DIV`, default 50000: `clk` cycles per digit slot (1 kHz digit rate at 50 MHz). Legal range is ≥ 2.
- `clk`, input, 1: system clock, same as the clock core's `clk`.
- `reset`, input, 1: reset is synchronous and active-high. One clock.
- `Hours`, input, 5: binary hours. Legal range 0–23; 24–31 is possible via the switch-set path.
- `Minutes`, input, 6: binary minutes. Legal range 0–59; 60–63 is possible via switch-set.
- `Seconds`, input, 6: binary seconds, 0–59.
- `Mode`, input, 1: 0 shows HH.MM; 1 shows MM.SS.
- `Anodes`, output, 4: digit enables, active-low. Bit 3 is the leftmost digit.
- `Segments`, output, 7: {g,f,e,d,c,b,a}, active-low.
- `DecimalPoint`, output, 1: active-low. Used only on the digit 2 slot.

## Operation
- Prescaler counts 0..REFRESH_DIV-1, then wraps. A tick occurs on the cycle where the count equals REFRESH_DIV-1.
- Digit index is 2 bits. On each tick, index ← index+1 mod 4.
- Snapshot registers (left value, right value, Seconds LSB) load on the tick that moves the index to 0.
  - Mode=0: left=Hours (zero-extended to 6 bits), right=Minutes.
  - Mode=1: left=Minutes, right=Seconds.
  - Mode is sampled only at this point. Input changes at any other time are ignored until the next frame.
- Digit mapping:
  - index 0 → anode 0, right ones
  - index 1 → anode 1, right tens
  - index 2 → anode 2, left ones
  - index 3 → anode 3, left tens
- Exactly one anode is low whenever the display is not blank.
- Binary-to-decimal conversion: tens = v/10, ones = v mod 10, for v ≤ limit. The limit is 23 for the left field in Mode=0 and 59 otherwise.
  - Out-of-range field: both of its digits show a dash (segment g only, `0111111`).
- Segment codes (gfedcba, active-low):
  - 0 = `1000000`, 1 = `1111001`, 2 = `0100100`, 3 = `0110000`, 4 = `0011001`
  - 5 = `0010010`, 6 = `0000010`, 7 = `1111000`, 8 = `0000000`, 9 = `0010000`
  - blank = `1111111`
- No leading-zero suppression. 7 h 5 m displays as 07.05.
- `DecimalPoint` is low only while index=2 and the snapshot Seconds LSB=0, which gives a colon blink. At all other times it is high.

## Timing
- Reset values:
  - prescaler 0, index 3, snapshot 0
  - `Anodes`=`1111`, `Segments`=`1111111`, `DecimalPoint`=1
  - a blank flag is set
- The display stays blank until the first tick after reset release. That tick wraps the index 3→0, takes the snapshot, and clears the blank flag.
- All outputs are registered from index and snapshot, with 1-cycle latency. Tick at cycle T moves the index at edge T. Outputs show the new digit from edge T+1. The previous digit is held one extra cycle.
- First digit after reset release: the prescaler reaches REFRESH_DIV-1 on the REFRESH_DIV-th cycle, and `Anodes`=`1110` one cycle after that.
- Frame period is 4·REFRESH_DIV cycles.
- A snapshot occurring in the same cycle as an input change captures the pre-edge input value.
- Reset asserted mid-frame: outputs are blank at the next edge and the sequence restarts as from power-up. Reset has priority over a coincident tick.

## Structure
- Shared package `display_pkg`:
  - segment code constants `SEG_0`..`SEG_9`, `SEG_DASH`, `SEG_BLANK`
  - `DIGIT_COUNT`=4
  - `HOURS_MAX`=23, `MINSEC_MAX`=59
- One sub-module, `two_digit_bcd`: combinational. Takes a 6-bit value and a limit. Produces tens[3:0], ones[3:0] and in_range.
  - Instantiated twice, for the left and right fields.
- Segment decode is a function in `display_pkg`.
- Prescaler, index, snapshot and output registers live in the top level.

## Test plan
All scenarios use REFRESH_DIV=4.
- Reset held for 3 cycles, then released → outputs all-ones until the first tick. `Anodes`=`1110` exactly 5 cycles after release. Sequence continues `1101`, `1011`, `0111` every 4 cycles.
- Hours=23, Minutes=59, Mode=0 → per frame, anodes 3,2,1,0 show `0100100`, `0110000`, `0010010`, `0010000`.
- Mode=1, Minutes=7, Seconds=42 → digits 0,7,4,2. `DecimalPoint`=0 only in the anode 2 slot.
- Hours=25, Minutes=5, Mode=0 → anodes 3,2 show `0111111`; anodes 1,0 show 0,5. Minutes=61 in Mode=1 → left pair shows dashes.
- Change Minutes 12→13 while index=1 → current frame still shows 12. The next frame shows 13. No frame mixes the two values.
- Reset asserted while index=2 → next edge all outputs blank. After release, the sequence restarts from anode 0 with the full REFRESH_DIV delay.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants, types and segment decoding for the multiplexed
// seven-segment time display.
package display_pkg;

  localparam int DIGIT_COUNT = 4;
  localparam logic [5:0] HOURS_MAX  = 6'd23;
  localparam logic [5:0] MINSEC_MAX = 6'd59;

  // Segment patterns are {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef logic [1:0] digit_idx_t;

  typedef struct packed {
    logic [5:0] left;
    logic [5:0] right;
    logic       sec_lsb;
    logic       left_is_min;
  } snapshot_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit, input logic valid);
    logic [6:0] seg;
    seg = SEG_BLANK;
    if (!valid) begin
      seg = SEG_DASH;
    end else begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
    return seg;
  endfunction

endpackage

// File: rtl/two_digit_bcd.sv
// Combinational split of a 6-bit field into decimal tens/ones with a
// range flag against a per-field upper limit.
module two_digit_bcd (
  input  logic [5:0] value,
  input  logic [5:0] limit,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       in_range
);

  logic [5:0] rem;

  // Repeated subtraction; six steps cover the full 0..63 input span
  always_comb begin
    rem  = value;
    tens = 4'd0;
    for (int i = 0; i < 6; i++) begin
      if (rem >= 6'd10) begin
        rem  = rem - 6'd10;
        tens = tens + 4'd1;
      end
    end
    ones     = rem[3:0];
    in_range = (value <= limit);
  end

endmodule

// File: rtl/time_display_scanner.sv
// Scans a frame-atomic snapshot of the time onto a 4-digit common-anode
// seven-segment display, showing HH.MM or MM.SS.
module time_display_scanner
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] Hours,
  input  logic [5:0] Minutes,
  input  logic [5:0] Seconds,
  input  logic       Mode,
  output logic [3:0] Anodes,
  output logic [6:0] Segments,
  output logic       DecimalPoint
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam digit_idx_t       IDX_LAST  = digit_idx_t'(DIGIT_COUNT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  digit_idx_t       idx_q, idx_d;
  logic             blank_q, blank_d;
  snapshot_t        snap_q, snap_d;
  logic [3:0]       anodes_q, anodes_d;
  logic [6:0]       segments_q, segments_d;
  logic             dp_q, dp_d;

  logic       tick;
  logic       frame_start;
  logic [5:0] left_limit;
  logic [3:0] l_tens, l_ones, r_tens, r_ones;
  logic       l_ok, r_ok;
  logic [3:0] digit;
  logic       digit_ok;

  assign left_limit = snap_q.left_is_min ? MINSEC_MAX : HOURS_MAX;

  two_digit_bcd u_left_bcd (
    .value    (snap_q.left),
    .limit    (left_limit),
    .tens     (l_tens),
    .ones     (l_ones),
    .in_range (l_ok)
  );

  two_digit_bcd u_right_bcd (
    .value    (snap_q.right),
    .limit    (MINSEC_MAX),
    .tens     (r_tens),
    .ones     (r_ones),
    .in_range (r_ok)
  );

  always_comb begin
    tick        = (cnt_q == CNT_LAST);
    frame_start = tick && (idx_q == IDX_LAST);
    cnt_d       = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d       = tick ? idx_q + digit_idx_t'(1) : idx_q;
    // The index resets to the last slot, so the first tick is always a frame start
    blank_d     = tick ? 1'b0 : blank_q;

    snap_d = snap_q;
    if (frame_start) begin
      snap_d.left        = Mode ? Minutes : {1'b0, Hours};
      snap_d.right       = Mode ? Seconds : Minutes;
      snap_d.sec_lsb     = Seconds[0];
      snap_d.left_is_min = Mode;
    end

    digit    = r_ones;
    digit_ok = r_ok;
    case (idx_q)
      2'd0: begin digit = r_ones; digit_ok = r_ok; end
      2'd1: begin digit = r_tens; digit_ok = r_ok; end
      2'd2: begin digit = l_ones; digit_ok = l_ok; end
      2'd3: begin digit = l_tens; digit_ok = l_ok; end
      default: begin digit = r_ones; digit_ok = r_ok; end
    endcase

    anodes_d   = blank_q ? 4'b1111 : ~(4'b0001 << idx_q);
    segments_d = blank_q ? SEG_BLANK : seg_decode(digit, digit_ok);
    dp_d       = ~(!blank_q && (idx_q == 2'd2) && !snap_q.sec_lsb);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      idx_q      <= IDX_LAST;
      blank_q    <= 1'b1;
      snap_q     <= '0;
      anodes_q   <= 4'b1111;
      segments_q <= SEG_BLANK;
      dp_q       <= 1'b1;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      blank_q    <= blank_d;
      snap_q     <= snap_d;
      anodes_q   <= anodes_d;
      segments_q <= segments_d;
      dp_q       <= dp_d;
    end
  end

  assign Anodes       = anodes_q;
  assign Segments     = segments_q;
  assign DecimalPoint = dp_q;

endmodule

// File: tb/tb_time_display_scanner.sv
// Self-checking bench for time_display_scanner with REFRESH_DIV=4: table of
// time vectors scored per digit slot, plus reset/timing/tearing sequences.
module tb_time_display_scanner;

  localparam int RD = 4;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SD = 7'b0111111;
  localparam logic [6:0] SB = 7'b1111111;
  localparam logic [11:0] BLANK = {4'b1111, 7'b1111111, 1'b1};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] Hours = '0;
  logic [5:0] Minutes = '0;
  logic [5:0] Seconds = '0;
  logic       Mode = 1'b0;
  logic [3:0] Anodes;
  logic [6:0] Segments;
  logic       DecimalPoint;

  int n_checks = 0;
  int n_fail   = 0;

  time_display_scanner #(.REFRESH_DIV(RD)) dut (
    .clk          (clk),
    .reset        (reset),
    .Hours        (Hours),
    .Minutes      (Minutes),
    .Seconds      (Seconds),
    .Mode         (Mode),
    .Anodes       (Anodes),
    .Segments     (Segments),
    .DecimalPoint (DecimalPoint)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  typedef struct {
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic       md;
    logic [6:0] seg3, seg2, seg1, seg0;
    logic       dp2;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[10];

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got an=%b seg=%b dp=%b, required an=%b seg=%b dp=%b",
               name, act[11:8], act[7:1], act[0], req[11:8], req[7:1], req[0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    edges(3);
    reset = 1'b0;
  endtask

  task automatic push_frame(input logic [6:0] seg3, input logic [6:0] seg2,
                            input logic [6:0] seg1, input logic [6:0] seg0, input logic dp2);
    sb_q.push_back('{an: 4'b1110, seg: seg0, dp: 1'b1});
    sb_q.push_back('{an: 4'b1101, seg: seg1, dp: 1'b1});
    sb_q.push_back('{an: 4'b1011, seg: seg2, dp: dp2});
    sb_q.push_back('{an: 4'b0111, seg: seg3, dp: 1'b1});
  endtask

  function automatic logic [11:0] outs();
    return {Anodes, Segments, DecimalPoint};
  endfunction

  // Each newly lit digit slot is scored against the next queued expectation
  logic [3:0] prev_an = 4'b1111;
  always @(negedge clk) begin
    exp_t e;
    if (Anodes !== prev_an && Anodes !== 4'b1111 && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("scoreboard digit", {Anodes, Segments, DecimalPoint}, {e.an, e.seg, e.dp});
    end
    prev_an = Anodes;
  end

  initial begin
    vecs[0] = '{5'd23, 6'd59, 6'd0,  1'b0, S2, S3, S5, S9, 1'b0};
    vecs[1] = '{5'd0,  6'd7,  6'd42, 1'b1, S0, S7, S4, S2, 1'b0};
    vecs[2] = '{5'd25, 6'd5,  6'd1,  1'b0, SD, SD, S0, S5, 1'b1};
    vecs[3] = '{5'd0,  6'd61, 6'd30, 1'b1, SD, SD, S3, S0, 1'b0};
    vecs[4] = '{5'd7,  6'd5,  6'd13, 1'b0, S0, S7, S0, S5, 1'b1};
    vecs[5] = '{5'd0,  6'd0,  6'd59, 1'b0, S0, S0, S0, S0, 1'b1};
    vecs[6] = '{5'd0,  6'd59, 6'd59, 1'b1, S5, S9, S5, S9, 1'b1};
    vecs[7] = '{5'd24, 6'd60, 6'd2,  1'b0, SD, SD, SD, SD, 1'b0};
    vecs[8] = '{5'd31, 6'd10, 6'd7,  1'b0, SD, SD, S1, S0, 1'b1};
    vecs[9] = '{5'd30, 6'd23, 6'd9,  1'b1, S2, S3, S0, S9, 1'b1};

    // Reset state and first-digit timing
    reset = 1'b1;
    edges(1);
    check("reset state", outs(), BLANK);
    edges(2);
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      edges(1);
      check("blank before first tick", outs(), BLANK);
    end
    edges(1);
    check("first digit anode0", outs(), {4'b1110, S0, 1'b1});
    edges(3);
    check("anode0 held", outs(), {4'b1110, S0, 1'b1});
    edges(1);
    check("anode1 slot", outs(), {4'b1101, S0, 1'b1});
    edges(4);
    check("anode2 slot", outs(), {4'b1011, S0, 1'b0});
    edges(4);
    check("anode3 slot", outs(), {4'b0111, S0, 1'b1});
    edges(4);
    check("frame wrap anode0", outs(), {4'b1110, S0, 1'b1});

    // Table of time values, one full frame each
    for (int v = 0; v < 10; v++) begin
      Hours   = vecs[v].h;
      Minutes = vecs[v].m;
      Seconds = vecs[v].s;
      Mode    = vecs[v].md;
      do_reset();
      push_frame(vecs[v].seg3, vecs[v].seg2, vecs[v].seg1, vecs[v].seg0, vecs[v].dp2);
      edges(22);
      check_int("frame drained", sb_q.size(), 0);
      sb_q.delete();
    end

    // Minutes change mid-frame must not tear the current frame
    Hours = 5'd10; Minutes = 6'd12; Seconds = 6'd1; Mode = 1'b0;
    do_reset();
    push_frame(S1, S0, S1, S2, 1'b1);
    edges(9);
    Minutes = 6'd13;
    push_frame(S1, S0, S1, S3, 1'b1);
    edges(29);
    check_int("no-tear frames drained", sb_q.size(), 0);
    sb_q.delete();

    // Reset during the anode 2 slot, coinciding with a tick
    Hours = '0; Minutes = '0; Seconds = '0; Mode = 1'b0;
    do_reset();
    edges(15);
    check("pre-reset anode2", outs(), {4'b1011, S0, 1'b0});
    reset = 1'b1;
    edges(1);
    check("mid-frame reset blank", outs(), BLANK);
    reset = 1'b0;
    edges(4);
    check("blank after mid-frame reset", outs(), BLANK);
    edges(1);
    check("restart anode0", outs(), {4'b1110, S0, 1'b1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
